// File: rtl/qam_demodulator.sv
// QAM demodulator: carrier mixing, integrate-and-dump per symbol, sign slicing to a 2-bit symbol.
// Optional macro QAM_DEMOD_SAT_EN makes the accumulators saturate instead of wrapping.
module qam_demodulator #(
  parameter int CLK_DIV        = 8,
  parameter int SYMBOL_SAMPLES = 125,
  parameter int ACC_W          = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sym_align,
  input  logic [7:0]       sample_in,
  input  logic [7:0]       sin_ref,
  input  logic [7:0]       cos_ref,
  output logic [1:0]       data_out,
  output logic             data_valid
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(SYMBOL_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, DECIDE = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]         sample_cnt_q, sample_cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0]  acc_q_q, acc_q_d;
  logic [1:0]               data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;

  logic                     tick_s;
  logic signed [15:0]       prod_i_s, prod_q_s;
  logic signed [ACC_W-1:0]  ext_i_s, ext_q_s;

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef QAM_DEMOD_SAT_EN
    // Differing top two bits of the widened sum mean the signed result left the range.
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      acc_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_add = sum[ACC_W-1:0];
    end
`else
    acc_add = sum[ACC_W-1:0];
`endif
  endfunction

  assign tick_s   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign prod_i_s = $signed(sample_in) * $signed(cos_ref);
  assign prod_q_s = $signed(sample_in) * $signed(sin_ref);
  assign ext_i_s  = ACC_W'(prod_i_s);
  assign ext_q_s  = ACC_W'(prod_q_s);

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    sample_cnt_d = sample_cnt_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (!en || sym_align) begin
      // Disable and realignment both discard any partial symbol.
      state_d      = en ? ACQ : IDLE;
      div_cnt_d    = '0;
      sample_cnt_d = '0;
      acc_i_d      = '0;
      acc_q_d      = '0;
    end else begin
      case (state_q)
        ACQ: begin
          div_cnt_d = tick_s ? '0 : div_cnt_q + 1'b1;
          if (tick_s) begin
            acc_i_d      = acc_add(acc_i_q, ext_i_s);
            acc_q_d      = acc_add(acc_q_q, ext_q_s);
            sample_cnt_d = sample_cnt_q + 1'b1;
            if (sample_cnt_q == CNT_W'(SYMBOL_SAMPLES - 1)) begin
              state_d = DECIDE;
            end else begin
              state_d = ACQ;
            end
          end else begin
            state_d = ACQ;
          end
        end
        DECIDE: begin
          // div_cnt keeps running so the symbol period never stretches.
          div_cnt_d    = tick_s ? '0 : div_cnt_q + 1'b1;
          data_out_d   = {~acc_i_q[ACC_W-1], ~acc_q_q[ACC_W-1]};
          data_valid_d = 1'b1;
          acc_i_d      = '0;
          acc_q_d      = '0;
          sample_cnt_d = '0;
          state_d      = ACQ;
        end
        default: begin
          state_d      = IDLE;
          div_cnt_d    = '0;
          sample_cnt_d = '0;
          acc_i_d      = '0;
          acc_q_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      sample_cnt_q <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      data_out_q   <= 2'b00;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule
